// File: rtl/pico_pkg.sv
// Shared definitions for the picoMips control sequencer.
//   OP_*         : 3-bit opcode values of instruction[7:5]
//   seq_state_t  : sequencer phase encoding
//   is_acc_op()  : opcode writes the accumulator in EXEC
//   is_reg_op()  : opcode writes the register file in WB
package pico_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LSW  = 3'b001;
    localparam logic [2:0] OP_RTA  = 3'b010;
    localparam logic [2:0] OP_ATR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_MULI = 3'b110;
    localparam logic [2:0] OP_HEI  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        WAIT_SW,
        HALTED
    } seq_state_t;

    function automatic logic is_acc_op(input logic [2:0] func);
        return (func == OP_RTA) || (func == OP_ADD) ||
               (func == OP_ADDI) || (func == OP_MULI);
    endfunction

    function automatic logic is_reg_op(input logic [2:0] func);
        return (func == OP_LSW) || (func == OP_ATR);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Synchronise and debounce an asynchronous switch.
//   Clock, nReset : clock, asynchronous active-low reset
//   raw           : raw switch level, asynchronous to Clock
//   db            : debounced level; changes 2 + DB_CYCLES cycles after a
//                   stable raw edge, ignores pulses shorter than DB_CYCLES
module sw_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic Clock,
    input  logic nReset,
    input  logic raw,
    output logic db
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stability counter: restarts whenever the synchronised level agrees
    // with the debounced one, flips the output after DB_CYCLES disagreements.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/pico_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for picoMips.
//   Clock, nReset : clock, asynchronous active-low reset
//   sw8_raw       : raw SW[8] used by HEI
//   func, hei_arg : opcode and HEI polarity of the current instruction
//   halt_req      : level debug halt, sampled in IDLE and WB only
//   step_req      : pulse, runs one instruction while halted
//   pc            : program counter, wraps at NUM_INSTR-1
//   fetch_en, reg_rd_en, acc_we, reg_we : datapath enables
//   waiting, halted : HEI stall and debug-halt flags
//   retired       : saturating retired-instruction count
// Every output is a flop loaded from the next-state decode, so it tracks
// the state register exactly and clears asynchronously with it.
module pico_sequencer #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned NUM_INSTR = 24,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic            sw8_raw,
    input  logic [2:0]      func,
    input  logic            hei_arg,
    input  logic            halt_req,
    input  logic            step_req,
    output logic [PC_W-1:0] pc,
    output logic            fetch_en,
    output logic            reg_rd_en,
    output logic            acc_we,
    output logic            reg_we,
    output logic            waiting,
    output logic            halted,
    output logic [15:0]     retired
);

    import pico_pkg::*;

    localparam int unsigned RET_W = 16;
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(NUM_INSTR - 1);
    localparam logic [RET_W-1:0] RET_MAX = '1;

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [RET_W-1:0] retired_q;
    logic [RET_W-1:0] retired_d;
    logic             fetch_en_q;
    logic             fetch_en_d;
    logic             reg_rd_en_q;
    logic             reg_rd_en_d;
    logic             acc_we_q;
    logic             acc_we_d;
    logic             reg_we_q;
    logic             reg_we_d;
    logic             waiting_q;
    logic             waiting_d;
    logic             halted_q;
    logic             halted_d;
    logic             sw8_db;

    sw_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_sw8_db (
        .Clock  (Clock),
        .nReset (nReset),
        .raw    (sw8_raw),
        .db     (sw8_db)
    );

    // Next-state, PC/retire update and output decode of the next state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;

        unique case (state_q)
            IDLE:    state_d = halt_req ? HALTED : FETCH;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = (func == OP_HEI) ? WAIT_SW : EXEC;
            EXEC:    state_d = WB;
            WAIT_SW: if (sw8_db != hei_arg) state_d = WB;
            WB: begin
                pc_d      = (pc_q == PC_LAST) ? '0 : pc_q + PC_W'(1);
                retired_d = (retired_q == RET_MAX) ? retired_q
                                                   : retired_q + RET_W'(1);
                state_d   = halt_req ? HALTED : FETCH;
            end
            // A step and a release both just enter FETCH; WB re-samples halt.
            HALTED:  if (step_req || !halt_req) state_d = FETCH;
            default: state_d = IDLE;
        endcase

        fetch_en_d  = (state_d == FETCH);
        reg_rd_en_d = (state_d == DECODE);
        acc_we_d    = (state_d == EXEC) && is_acc_op(func);
        reg_we_d    = (state_d == WB) && is_reg_op(func);
        waiting_d   = (state_d == WAIT_SW);
        halted_d    = (state_d == HALTED);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            retired_q   <= '0;
            fetch_en_q  <= 1'b0;
            reg_rd_en_q <= 1'b0;
            acc_we_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            waiting_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            fetch_en_q  <= fetch_en_d;
            reg_rd_en_q <= reg_rd_en_d;
            acc_we_q    <= acc_we_d;
            reg_we_q    <= reg_we_d;
            waiting_q   <= waiting_d;
            halted_q    <= halted_d;
        end
    end

    assign pc        = pc_q;
    assign retired   = retired_q;
    assign fetch_en  = fetch_en_q;
    assign reg_rd_en = reg_rd_en_q;
    assign acc_we    = acc_we_q;
    assign reg_we    = reg_we_q;
    assign waiting   = waiting_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_pico_sequencer.sv
// Directed self-checking bench for pico_sequencer (defaults: 24 instructions,
// DB_CYCLES=4). Program memory is modelled by prog_f/prog_a indexed by pc.
module tb_pico_sequencer;

    logic        Clock = 1'b0;
    logic        nReset = 1'b1;
    logic        sw8_raw = 1'b0;
    logic [2:0]  func;
    logic        hei_arg;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic [7:0]  pc;
    logic        fetch_en, reg_rd_en, acc_we, reg_we, waiting, halted;
    logic [15:0] retired;

    logic [2:0]  prog_f [0:255];
    logic        prog_a [0:255];
    logic [5:0]  outs;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    pico_sequencer dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .sw8_raw   (sw8_raw),
        .func      (func),
        .hei_arg   (hei_arg),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .pc        (pc),
        .fetch_en  (fetch_en),
        .reg_rd_en (reg_rd_en),
        .acc_we    (acc_we),
        .reg_we    (reg_we),
        .waiting   (waiting),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        func    = prog_f[pc];
        hei_arg = prog_a[pc];
    end

    // {fetch_en, reg_rd_en, acc_we, reg_we, waiting, halted}
    assign outs = {fetch_en, reg_rd_en, acc_we, reg_we, waiting, halted};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    // Runs one instruction starting in FETCH; ends one tick after WB.
    task automatic do_instr(input logic [7:0] ep, input int wait_n);
        logic [2:0] f;
        logic       acc, rg;
        f   = prog_f[ep];
        acc = (f == 3'b010) || (f == 3'b100) || (f == 3'b101) || (f == 3'b110);
        rg  = (f == 3'b001) || (f == 3'b011);
        chk("fetch_outs", 32'(outs), 32'(6'b100000));
        chk("fetch_pc", 32'(pc), 32'(ep));
        tick();
        chk("decode_outs", 32'(outs), 32'(6'b010000));
        tick();
        if (f == 3'b111) begin
            for (int i = 0; i < wait_n; i++) begin
                chk("wait_outs", 32'(outs), 32'(6'b000010));
                tick();
            end
        end else begin
            chk("exec_outs", 32'(outs), 32'({2'b00, acc, 3'b000}));
            tick();
        end
        chk("wb_outs", 32'(outs), 32'({3'b000, rg, 2'b00}));
        chk("wb_pc", 32'(pc), 32'(ep));
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            prog_f[i] = 3'b100;
            prog_a[i] = 1'b0;
        end
        prog_f[4] = 3'b111; prog_a[4] = 1'b0;
        prog_f[5] = 3'b111; prog_a[5] = 1'b1;

        // Reset state
        #2 nReset = 1'b0;
        #1;
        chk("rst_outs", 32'(outs), 32'(0));
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        tick();
        chk("rst_hold_outs", 32'(outs), 32'(0));
        #2 nReset = 1'b1;
        cyc = 0;
        chk("idle_outs", 32'(outs), 32'(0));

        // ADD stream: fetch on 1,5,9; retired=3 at cycle 13
        tick();
        do_instr(8'd0, 0);
        do_instr(8'd1, 0);
        do_instr(8'd2, 0);
        chk("cycle13_retired", 32'(retired), 32'(3));
        chk("cycle13_fetch", 32'(outs), 32'(6'b100000));
        do_instr(8'd3, 0);

        // HEI arg=0, SW8 raised in cycle 20: release at 26, WB 27, pc=5 at 28
        chk("hei_fetch", 32'(outs), 32'(6'b100000));
        chk("hei_pc", 32'(pc), 32'(4));
        tick();
        chk("hei_decode", 32'(outs), 32'(6'b010000));
        tick();
        chk("hei_wait19", 32'(outs), 32'(6'b000010));
        tick();
        chk("hei_wait20", 32'(outs), 32'(6'b000010));
        sw8_raw = 1'b1;
        while (cyc < 26) begin
            tick();
            chk("hei_wait_db", 32'(outs), 32'(6'b000010));
        end
        tick();
        chk("hei_wb27", 32'(outs), 32'(0));
        chk("hei_wb27_pc", 32'(pc), 32'(4));
        tick();
        chk("hei_fetch28", 32'(outs), 32'(6'b100000));
        chk("hei_pc28", 32'(pc), 32'(5));
        chk("hei_retired", 32'(retired), 32'(5));

        // HEI arg=1 with a 2-cycle low glitch on SW8: stays waiting
        tick();
        chk("glitch_decode", 32'(outs), 32'(6'b010000));
        tick();
        chk("glitch_wait30", 32'(outs), 32'(6'b000010));
        tick();
        sw8_raw = 1'b0;
        tick();
        tick();
        sw8_raw = 1'b1;
        while (cyc < 40) begin
            tick();
            chk("glitch_waiting", 32'(outs), 32'(6'b000010));
            chk("glitch_pc", 32'(pc), 32'(5));
        end

        // Asynchronous reset in WAIT_SW
        nReset = 1'b0;
        #1;
        chk("midrst_outs", 32'(outs), 32'(0));
        chk("midrst_pc", 32'(pc), 32'(0));
        chk("midrst_retired", 32'(retired), 32'(0));
        sw8_raw = 1'b0;
        prog_f[0] = 3'b000; prog_f[1] = 3'b001; prog_f[2] = 3'b010;
        prog_f[3] = 3'b101; prog_f[5] = 3'b110; prog_f[23] = 3'b011;
        prog_a[4] = 1'b1;
        tick();
        #2 nReset = 1'b1;
        cyc = 0;
        chk("idle2_outs", 32'(outs), 32'(0));
        tick();

        // Full program incl. 5-cycle HEI (already released) and pc wrap on ATR
        for (int p = 0; p < 24; p++) begin
            do_instr(8'(p), 1);
        end
        chk("wrap_pc", 32'(pc), 32'(0));
        chk("wrap_retired", 32'(retired), 32'(24));

        // Halt raised in EXEC: instruction completes, then HALTED
        chk("halt_fetch", 32'(outs), 32'(6'b100000));
        tick();
        tick();
        halt_req = 1'b1;
        chk("halt_exec", 32'(outs), 32'(0));
        tick();
        chk("halt_wb", 32'(outs), 32'(0));
        tick();
        chk("halted_outs", 32'(outs), 32'(6'b000001));
        chk("halted_pc", 32'(pc), 32'(1));
        chk("halted_retired", 32'(retired), 32'(25));
        tick();
        chk("halted_hold", 32'(outs), 32'(6'b000001));
        chk("halted_hold_pc", 32'(pc), 32'(1));

        // Two single steps
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        do_instr(8'd1, 0);
        chk("step1_halted", 32'(outs), 32'(6'b000001));
        chk("step1_pc", 32'(pc), 32'(2));
        tick();
        chk("step1_frozen_pc", 32'(pc), 32'(2));
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        do_instr(8'd2, 0);
        chk("step2_halted", 32'(outs), 32'(6'b000001));
        chk("step2_pc", 32'(pc), 32'(3));
        chk("step2_retired", 32'(retired), 32'(27));

        // Resume
        halt_req = 1'b0;
        tick();
        chk("resume_fetch", 32'(outs), 32'(6'b100000));
        chk("resume_pc", 32'(pc), 32'(3));

        // halt_req held through reset release: IDLE goes straight to HALTED
        nReset = 1'b0;
        halt_req = 1'b1;
        #1;
        chk("rst3_outs", 32'(outs), 32'(0));
        #2 nReset = 1'b1;
        tick();
        chk("idle_halt_outs", 32'(outs), 32'(6'b000001));
        chk("idle_halt_pc", 32'(pc), 32'(0));
        halt_req = 1'b0;
        tick();
        chk("idle_resume", 32'(outs), 32'(6'b100000));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pico_sequencer.md
Name: pico_sequencer

Overview:
- Multi-cycle control sequencer for the picoMips core.
- Owns the program counter and splits each instruction into explicit FETCH / DECODE / EXEC / WB phases.
- Generates the fetch, register-read, accumulator-write and register-write enables for the datapath.
- Implements the HEI wait-on-SW8 handshake through a synchronised, debounced switch input.
- Adds debug halt and single-step control.

Parameters:
- PC_W, 8: program counter width.
- NUM_INSTR, 24: program length. The PC wraps from NUM_INSTR-1 to 0.
- DB_CYCLES, 4: consecutive stable samples required before the debounced SW8 changes. Must be >= 1.

Ports:
- Clock  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- sw8_raw  in  1  raw SW[8], asynchronous to Clock
- func  in  3  opcode field of the current instruction register (instruction[7:5])
- hei_arg  in  1  instruction[0]; HEI wait polarity
- halt_req  in  1  level debug halt request
- step_req  in  1  single-cycle pulse; executes one instruction while halted
- pc  out  PC_W  program counter, used to address program memory
- fetch_en  out  1  load instruction register
- reg_rd_en  out  1  register file synchronous read strobe
- acc_we  out  1  accumulator write enable
- reg_we  out  1  register file write enable
- waiting  out  1  high while stalled on HEI
- halted  out  1  high in HALTED
- retired  out  16  retired-instruction count, saturating

Behaviour:
- Reset (nReset low, asynchronous), all registered:
  - state=IDLE, pc=0, retired=0.
  - Debounced SW8 = 0; synchroniser flops = 0.
  - All enables and flags = 0.
- States: IDLE, FETCH, DECODE, EXEC, WB, WAIT_SW, HALTED. All enables and flags are Moore outputs decoded from state.
- IDLE:
  - Lasts one cycle after reset release.
  - Goes to HALTED if halt_req=1, else to FETCH.
- Normal instruction (4 cycles): FETCH -> DECODE -> EXEC -> WB.
  - fetch_en=1 in FETCH only.
  - reg_rd_en=1 in DECODE only.
  - acc_we=1 in EXEC only when func is RTA(010), ADD(100), ADDI(101) or MULI(110).
  - reg_we=1 in WB only when func is LSW(001) or ATR(011).
- func=000 is a NOP: 4 cycles, no writes, still retired.
- HEI (func=111):
  - DECODE goes to WAIT_SW instead of EXEC.
  - WAIT_SW holds while sw8_db == hei_arg, with waiting=1.
  - When sw8_db != hei_arg, goes to WB the next cycle. No enables are asserted for HEI.
  - If SW8 is already at the released level, WAIT_SW lasts exactly 1 cycle, giving a 5-cycle HEI.
- On leaving WB:
  - pc <= (pc == NUM_INSTR-1) ? 0 : pc+1.
  - retired <= retired+1, saturating at 16'hFFFF.
  - Next state is HALTED if halt_req=1, else FETCH.
- halt_req is sampled only in WB and IDLE. It never aborts an instruction mid-phase, including during WAIT_SW.
- HALTED:
  - halted=1, pc frozen.
  - step_req=1 goes to FETCH and runs exactly one instruction; WB then re-samples halt_req.
  - halt_req=0 with step_req=0 goes to FETCH (resume).
  - If both step_req=1 and halt_req=0, one FETCH is entered, identical either way.
- SW8 path:
  - 2-flop synchroniser, then a counter that resets whenever the synchronised value equals sw8_db.
  - When the counter reaches DB_CYCLES-1 with the value still differing, sw8_db flips.
  - Latency from sw8_raw edge to sw8_db change is 2 + DB_CYCLES cycles.
  - Glitches shorter than DB_CYCLES samples are ignored.
- Reset mid-instruction returns immediately to IDLE with pc=0. No partial write is permitted: enables drop asynchronously with the state.

Decomposition:
- pico_pkg:
  - opcode localparams OP_NOP..OP_HEI (3-bit).
  - typedef enum logic [2:0] seq_state_t {IDLE, FETCH, DECODE, EXEC, WB, WAIT_SW, HALTED}.
  - helper functions is_acc_op(func) and is_reg_op(func).
- Sub-module sw_debounce(Clock, nReset, raw, db), parameterised by DB_CYCLES. It contains the synchroniser and the debounce counter.

Test Plan:
- Reset release, halt_req=0, program of ADD ops -> one IDLE cycle, then fetch_en on cycles 1, 5, 9, ...; acc_we on cycles 3, 7, ...; pc 0,1,2 incrementing every 4 cycles; retired=3 after 13 cycles.
- HEI hei_arg=0 with SW8=0, raise SW8 at cycle 20, DB_CYCLES=4 -> waiting=1 until sw8_db rises at cycle 26; WB at 27; pc increments at 28.
- SW8 glitch high for 2 cycles during HEI wait -> sw8_db stays 0, waiting stays 1, pc unchanged.
- pc=23 (NUM_INSTR=24), ATR op -> reg_we=1 in WB; pc becomes 0 next; retired increments.
- halt_req raised during EXEC -> instruction completes, pc advances, HALTED entered; two step_req pulses -> exactly 2 instructions retired, halted returns to 1 after each.
- Assert nReset during WAIT_SW at pc=5 -> pc=0, all enables 0, waiting=0 immediately; IDLE on release, then FETCH.
